// File: rtl/vec100_assembler.sv
// vec100_assembler: packs CHUNK_W-bit chunks into one OUT_W-bit word.
// Chunk k of a word lands at out[k*CHUNK_W +: CHUNK_W]. A word ends after
// NUM_CHUNKS chunks, or earlier when in_last is seen. The finished word is
// held on out until the downstream stage takes it with out_ready.
module vec100_assembler #(
  parameter  int CHUNK_W    = 10,
  parameter  int NUM_CHUNKS = 10,
  localparam int OUT_W      = CHUNK_W * NUM_CHUNKS
) (
  input  logic               clk,
  input  logic               aresetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CHUNK_W-1:0] in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out,
  output logic               out_short
);

  localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CHUNKS - 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [OUT_W-1:0] out_reg, out_next;
  logic             short_reg, short_next;
  logic             run_reg;

  logic accept;
  logic first;
  logic term;

  // Handshake outputs come from registers only. run_reg keeps in_ready low
  // during reset and until the first clock edge after reset is released.
  assign in_ready  = run_reg && (state_reg == FILL);
  assign out_valid = (state_reg == HOLD);
  assign out       = out_reg;
  assign out_short = short_reg;

  assign accept = in_valid && in_ready;
  assign first  = accept && (cnt_reg == '0);
  assign term   = accept && (in_last || (cnt_reg == CNT_LAST));

  // Per-chunk lanes: load the chunk addressed by cnt; the first chunk of a
  // word clears every other lane so nothing from the previous word survives
  // and an early-terminated word reads zero above its last chunk.
  for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_lane
    localparam logic [CNT_W-1:0] LANE = CNT_W'(gi);
    assign out_next[gi*CHUNK_W +: CHUNK_W] =
      (accept && (cnt_reg == LANE)) ? in_data :
      first                         ? '0      :
                                      out_reg[gi*CHUNK_W +: CHUNK_W];
  end

  // Ready-enable flag: low in reset, high from the first edge afterwards.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) run_reg <= 1'b0;
    else          run_reg <= 1'b1;
  end

  // State, counter, assembled word and short flag registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg <= FILL;
      cnt_reg   <= '0;
      out_reg   <= '0;
      short_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      out_reg   <= out_next;
      short_reg <= short_next;
    end
  end

  // Next-state logic: count chunks in FILL, wait for the consumer in HOLD.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    short_next = short_reg;
    case (state_reg)
      FILL: begin
        if (accept) begin
          if (term) begin
            state_next = HOLD;
            cnt_next   = '0;
            // in_last on the final chunk is a normal full word
            short_next = (cnt_reg != CNT_LAST);
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

endmodule

// File: doc/vec100_assembler.md
VEC100_ASSEMBLER -- requirements
Module: vec100_assembler

Interface
REQ-001 Parameter CHUNK_W, default 10, is the width of one input chunk in bits.
REQ-002 Parameter NUM_CHUNKS, default 10, is the number of chunks per assembled word; OUT_W = CHUNK_W*NUM_CHUNKS (default 100).
REQ-003 Port clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 Port aresetn  input  1  is the asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  marks in_data/in_last valid this cycle.
REQ-006 Port in_ready  output  1  marks the block accepting a chunk this cycle.
REQ-007 Port in_data  input  CHUNK_W  is the chunk payload.
REQ-008 Port in_last  input  1  marks the final chunk of a word (early termination allowed).
REQ-009 Port out_valid  output  1  marks an assembled word presented on out.
REQ-010 Port out_ready  input  1  marks the downstream 100-bit reduction stage consuming the word.
REQ-011 Port out  output  OUT_W  is the assembled word; it feeds the reduction stage's 100-bit input directly.
REQ-012 Port out_short  output  1  marks a word terminated by in_last before NUM_CHUNKS chunks.

Function
REQ-013 Chunk accept = in_valid && in_ready at a rising clk edge; out handshake = out_valid && out_ready.
REQ-014 The block SHALL be a two-state FSM: FILL (collecting chunks) and HOLD (presenting the word).
REQ-015 In FILL, in_ready = 1 and out_valid = 0; in HOLD, in_ready = 0 and out_valid = 1; both are decoded from registered state only, with no combinational path from any input.
REQ-016 A chunk counter cnt (0..NUM_CHUNKS-1) SHALL place the k-th accepted chunk of a word at out[k*CHUNK_W +: CHUNK_W]; the first chunk lands at bits [CHUNK_W-1:0].
REQ-017 At the first accepted chunk of a word (cnt = 0), all bits above the chunk SHALL be cleared, so no bits survive from the previous word.
REQ-018 FILL -> HOLD on the accept edge where cnt = NUM_CHUNKS-1 or in_last = 1; cnt returns to 0 on that edge.
REQ-019 out_short SHALL be registered 1 when the transition is caused by in_last with cnt < NUM_CHUNKS-1, and 0 otherwise; in_last on the final chunk is ignored.
REQ-020 On early termination, bits above the last accepted chunk SHALL read 0.
REQ-021 Latency: out_valid rises the cycle after the terminating chunk is accepted.
REQ-022 HOLD -> FILL on the out handshake edge; out and out_short SHALL hold stable throughout HOLD until that edge.
REQ-023 out SHALL retain the consumed word's value after HOLD -> FILL until the next first chunk is accepted.
REQ-024 Throughput: at most one word per NUM_CHUNKS+1 cycles, reached when out_ready is held 1.
REQ-025 in_valid while in_ready = 0 SHALL have no effect, and in_data is not captured.
REQ-026 in_valid = 0 in FILL SHALL stall without changing cnt or out.

Reset
REQ-027 aresetn = 0 SHALL immediately force state = FILL, cnt = 0, out = 0, out_short = 0 and out_valid = 0, independent of clk.
REQ-028 While aresetn = 0, in_ready SHALL be 0; it becomes 1 after the first rising clk edge with aresetn = 1.
REQ-029 Reset asserted mid-word or in HOLD SHALL discard the partial or held word; no out_valid follows it.

Verification
REQ-030 Send 10 chunks 10'h3FF with out_ready = 1 and no gaps -> one cycle later out = all-ones (100 bits), out_valid = 1, out_short = 0; reduction-stage AND = 1, OR = 1, XOR = 0.
REQ-031 Send chunks 0,1,...,9 with in_valid toggling every other cycle -> out[k*10 +: 10] = k for each k, and out_valid appears exactly once.
REQ-032 Send 3 chunks 10'h3FF with in_last on the 3rd -> out = 100'h3FFFFFFF, out_short = 1.
REQ-033 Hold out_ready = 0 for 5 cycles in HOLD while in_valid = 1 with in_data = 10'h155 -> in_ready = 0, out unchanged; the next word assembles only after out_ready = 1.
REQ-034 Pulse aresetn low between clk edges after 4 chunks are accepted -> outputs zero immediately; the next 10 chunks form a clean word with no stale bits.
REQ-035 Send a full word, then a short word of 1 chunk 10'h001 -> out = 100'h1, out_short = 1, with no residue from the previous word.
